// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus (CDB) arbiter.
// Holds the default bus geometry, the Reg_No_Lock idle tag, requester IDs
// and a small round-robin wrap helper shared by the arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_NUM_REQ    = 3;
    localparam int unsigned CDB_INDEX_W    = 5;   // Reg_Lock_Width equivalent
    localparam int unsigned CDB_DATA_W     = 32;  // Data_Width equivalent
    localparam int unsigned CDB_FIFO_DEPTH = 2;

    // ROB tag 0 means "no lock": an idle bus, never broadcast.
    localparam int unsigned REG_NO_LOCK = 0;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSM = 1;
    localparam int unsigned REQ_BRA = 2;

    // Width of the broadcast source field.
    localparam int unsigned SRC_W = 2;

    // Reduce an index in [0, 2n) into [0, n).
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester holding FIFO for the CDB arbiter.
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous active-high reset (empties the FIFO)
//   flush_i  - synchronous clear; overrides push and pop
//   push_i   - write wdata_i (ignored when full)
//   pop_i    - drop the head entry (ignored when empty)
//   wdata_i  - entry to write
//   empty_o  - no entries held
//   full_o   - DEPTH entries held (from registered count only)
//   head_o   - oldest entry
module cdb_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             empty_o,
    output logic             full_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even if it pops in the same cycle.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Depth is a power of two, so pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: shares the single common data bus broadcast slot between the
// ALU, load/store machine and branch unit. Each requester pushes
// {ROB index, result} into a private holding FIFO; a round-robin scheduler
// pops one head per cycle onto the registered CDB output.
// Optional feature macro: CDB_PERF_CNT_EN adds saturating grant/conflict counters.
// Ports:
//   clk_i, rst_i         - clock, asynchronous active-high reset
//   flush_i              - ROB misprediction flush (clears FIFOs and bus)
//   req_valid_i          - per-requester push strobe
//   req_index_i          - packed ROB tags, requester i at slice i
//   req_result_i         - packed results
//   req_stall_o          - requester i's FIFO is full
//   cdb_out_valid_o      - broadcast valid
//   cdb_out_index_o      - broadcast tag (0 when idle)
//   cdb_out_result_o     - broadcast data (0 when idle)
//   cdb_out_src_o        - requester number of the broadcast
//   perf_grant_cnt_o     - (CDB_PERF_CNT_EN) per-requester 16-bit grant counts
//   perf_conflict_cnt_o  - (CDB_PERF_CNT_EN) cycles with >= 2 non-empty FIFOs
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = CDB_NUM_REQ,
    parameter int unsigned INDEX_W    = CDB_INDEX_W,
    parameter int unsigned DATA_W     = CDB_DATA_W,
    parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*INDEX_W-1:0] req_index_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_result_i,
    output logic [NUM_REQ-1:0]         req_stall_o,
    output logic                       cdb_out_valid_o,
    output logic [INDEX_W-1:0]         cdb_out_index_o,
    output logic [DATA_W-1:0]          cdb_out_result_o,
    output logic [SRC_W-1:0]           cdb_out_src_o
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]      perf_grant_cnt_o,
    output logic [15:0]                perf_conflict_cnt_o
`endif
);

    localparam int unsigned EntW = INDEX_W + DATA_W;

    logic [NUM_REQ-1:0] fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [EntW-1:0]    fifo_head [NUM_REQ];

    logic               grant_found;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               valid_q, valid_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [SRC_W-1:0]   src_q, src_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        logic [INDEX_W-1:0] idx;
        assign idx = req_index_i[g*INDEX_W +: INDEX_W];

        // Tag 0 pushes are swallowed here so they never occupy a slot.
        assign fifo_push[g] = req_valid_i[g] && (idx != INDEX_W'(REG_NO_LOCK)) && !flush_i;
        assign fifo_pop[g]  = grant_found && (winner == SRC_W'(g));

        cdb_req_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EntW)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (fifo_push[g]),
            .pop_i   (fifo_pop[g]),
            .wdata_i ({idx, req_result_i[g*DATA_W +: DATA_W]}),
            .empty_o (fifo_empty[g]),
            .full_o  (fifo_full[g]),
            .head_o  (fifo_head[g])
        );
    end

    assign req_stall_o = fifo_full;

    // Round-robin scan starting at rr_ptr_q; first non-empty FIFO wins.
    always_comb begin
        logic [SRC_W-1:0] cand;
        grant_found = 1'b0;
        winner      = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'(rr_wrap(32'(rr_ptr_q) + k, NUM_REQ));
            if (!grant_found && !fifo_empty[cand]) begin
                grant_found = 1'b1;
                winner      = cand;
            end
        end
    end

    always_comb begin
        valid_d  = 1'b0;
        index_d  = '0;
        result_d = '0;
        src_d    = '0;
        rr_ptr_d = rr_ptr_q;
        if (!flush_i && grant_found) begin
            valid_d             = 1'b1;
            {index_d, result_d} = fifo_head[winner];
            src_d               = winner;
            rr_ptr_d            = SRC_W'(rr_wrap(32'(winner) + 1, NUM_REQ));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            index_q  <= '0;
            result_q <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            index_q  <= index_d;
            result_q <= result_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_out_valid_o  = valid_q;
    assign cdb_out_index_o  = index_q;
    assign cdb_out_result_o = result_q;
    assign cdb_out_src_o    = src_q;

`ifdef CDB_PERF_CNT_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] grant_cnt_d [NUM_REQ];
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        int unsigned busy;
        busy = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (fifo_pop[i] && !flush_i && grant_cnt_q[i] != 16'hFFFF) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
            end
            if (!fifo_empty[i]) busy = busy + 1;
        end
        conflict_cnt_d = conflict_cnt_q;
        if (busy >= 2 && conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_REQ); i++) grant_cnt_q[i] <= '0;
            conflict_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) grant_cnt_q[i] <= grant_cnt_d[i];
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_grant_cnt_o[g*16 +: 16] = grant_cnt_q[g];
    end
    assign perf_conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int NR = 3;
    localparam int IW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*IW-1:0]  req_index = '0;
    logic [NR*DW-1:0]  req_result = '0;
    logic [NR-1:0]     req_stall;
    logic              cdb_valid;
    logic [IW-1:0]     cdb_index;
    logic [DW-1:0]     cdb_result;
    logic [1:0]        cdb_src;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq [NR][$];
    int   m_rr = 0;

    cdb_arbiter dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .req_valid_i      (req_valid),
        .req_index_i      (req_index),
        .req_result_i     (req_result),
        .req_stall_o      (req_stall),
        .cdb_out_valid_o  (cdb_valid),
        .cdb_out_index_o  (cdb_index),
        .cdb_out_result_o (cdb_result),
        .cdb_out_src_o    (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [IW-1:0] ix,
                           input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_index[i*IW +: IW]  = ix;
        req_result[i*DW +: DW] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) mq[i].delete();
    endtask

    // One clock: check stall, advance the model, clock the DUT, check the bus.
    task automatic step();
        int   win;
        bit   acc [NR];
        bit   e_valid;
        ent_t e;
        int   e_src;
        for (int i = 0; i < NR; i++)
            chk($sformatf("stall%0d", i), 64'(req_stall[i]), 64'(mq[i].size() >= 2));
        win = -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_rr + k) % NR;
            if (win < 0 && mq[i].size() > 0) win = i;
        end
        for (int i = 0; i < NR; i++)
            acc[i] = req_valid[i] && mq[i].size() < 2 && req_index[i*IW +: IW] != 0 && !flush;
        e_valid = 1'b0;
        e       = '0;
        e_src   = 0;
        if (flush) begin
            model_clear();
        end else if (win >= 0) begin
            e       = mq[win].pop_front();
            e_valid = 1'b1;
            e_src   = win;
            m_rr    = (win + 1) % NR;
        end
        for (int i = 0; i < NR; i++)
            if (acc[i]) mq[i].push_back({req_index[i*IW +: IW], req_result[i*DW +: DW]});
        @(posedge clk);
        #1;
        chk("valid", 64'(cdb_valid), 64'(e_valid));
        chk("index", 64'(cdb_index), 64'(e.idx));
        chk("result", 64'(cdb_result), 64'(e.data));
        chk("src", 64'(cdb_src), 64'(e_src));
    endtask

    initial begin
        // Reset values while reset is held.
        #12;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_index", 64'(cdb_index), 64'd0);
        chk("rst_result", 64'(cdb_result), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        chk("rst_stall", 64'(req_stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin from rr_ptr = 0: tags 1, 2, 3 in requester order.
        set_req(0, 1, 5'd1, 32'hA000_0001);
        set_req(1, 1, 5'd2, 32'hA000_0002);
        set_req(2, 1, 5'd3, 32'hA000_0003);
        step();
        req_valid = '0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("rr_tag%0d", n), 64'(cdb_index), 64'(n + 1));
            chk($sformatf("rr_src%0d", n), 64'(cdb_src), 64'(n));
        end
        step();

        // Single ALU push: visible one edge later, for exactly one cycle.
        set_req(0, 1, 5'd3, 32'h1234_5678);
        step();
        req_valid = '0;
        step();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_index", 64'(cdb_index), 64'd3);
        chk("single_result", 64'(cdb_result), 64'h1234_5678);
        step();
        chk("single_gone", 64'(cdb_valid), 64'd0);

        // Stall: everyone pushes, LSM fills up and its extra push is dropped.
        for (int n = 0; n < 4; n++) begin
            set_req(0, 1, 5'(8 + n), 32'hB000_0000 + 32'(n));
            set_req(1, 1, 5'(12 + n), 32'hC000_0000 + 32'(n));
            set_req(2, 1, 5'(16 + n), 32'hD000_0000 + 32'(n));
            step();
            if (n == 2) chk("lsm_stall", 64'(req_stall[1]), 64'd1);
        end
        req_valid = '0;
        for (int n = 0; n < 8; n++) step();

        // Flush: BRA entries queued plus an ALU push in the flush cycle.
        set_req(2, 1, 5'd20, 32'hE000_0000);
        step();
        set_req(2, 1, 5'd21, 32'hE000_0001);
        set_req(0, 1, 5'd22, 32'hE000_0002);
        step();
        set_req(2, 1, 5'd23, 32'hE000_0003);
        set_req(0, 1, 5'd24, 32'hE000_0004);
        flush = 1'b1;
        step();
        flush = 1'b0;
        req_valid = '0;
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_stall", 64'(req_stall), 64'd0);
        step();
        chk("flush_nobcast", 64'(cdb_valid), 64'd0);

        // Tag 0 pushes are discarded.
        set_req(1, 1, 5'd0, 32'hDEAD_BEEF);
        step();
        step();
        req_valid = '0;
        chk("zero_stall", 64'(req_stall[1]), 64'd0);
        step();
        chk("zero_nobcast", 64'(cdb_valid), 64'd0);

        // Async reset while a broadcast is on the bus.
        set_req(0, 1, 5'd9, 32'hFACE_0009);
        step();
        req_valid = '0;
        step();
        chk("pre_rst_valid", 64'(cdb_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(cdb_valid), 64'd0);
        chk("arst_index", 64'(cdb_index), 64'd0);
        chk("arst_result", 64'(cdb_result), 64'd0);
        chk("arst_stall", 64'(req_stall), 64'd0);
        model_clear();
        m_rr = 0;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++) begin
                logic [IW-1:0] ix;
                ix = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                set_req(i, $urandom_range(0, 99) < 60, ix, $urandom);
            end
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;
        req_valid = '0;
        for (int n = 0; n < 8; n++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) broadcast slot between the functional units: ALU, load/store machine and branch unit.
- Each requester pushes {ROB index, result} into a private 2-entry holding FIFO.
- A round-robin scheduler pops one head per cycle onto the registered CDB output, which feeds the reservation stations and the ROB.
- Back-pressure goes to each unit through a per-requester stall bit.

Parameters:
- NUM_REQ, 3, number of requesters (0 = ALU, 1 = LSM, 2 = BRA).
- INDEX_W, 5, ROB tag width. Value 0 is Reg_No_Lock and means an idle bus.
- DATA_W, 32, result width.
- FIFO_DEPTH, 2, holding entries per requester (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  ROB misprediction flush; synchronous, one cycle.
- req_valid  in  NUM_REQ  per-requester push strobe.
- req_index  in  NUM_REQ*INDEX_W  packed ROB tags; requester i occupies slice i.
- req_result  in  NUM_REQ*DATA_W  packed results.
- req_stall  out  NUM_REQ  holding FIFO of requester i is full.
- cdb_out_valid  out  1  broadcast valid.
- cdb_out_index  out  INDEX_W  broadcast tag; 0 when idle.
- cdb_out_result  out  DATA_W  broadcast data; 0 when idle.
- cdb_out_src  out  2  requester number of the current broadcast.

Behaviour:
- Reset (async, active-high):
  - All FIFOs empty, counts 0.
  - Round-robin pointer rr_ptr = 0.
  - cdb_out_valid = 0, cdb_out_index = 0, cdb_out_result = 0, cdb_out_src = 0.
  - req_stall = 0.
- Push rules:
  - req_stall[i] = (count_i == FIFO_DEPTH). It is decoded from registered count only, with no combinational path from the inputs.
  - Push occurs on a rising edge when req_valid[i] && !req_stall[i].
  - A push while stalled is dropped. The requester must hold its data and retry.
  - A push with index 0 is discarded and never broadcast.
- Arbitration, evaluated every cycle on registered FIFO state:
  - Scan i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ. The first non-empty FIFO wins.
  - On the next edge, its head is registered onto cdb_out_*, with cdb_out_valid = 1 and cdb_out_src = winner.
  - The head is popped and rr_ptr <= (winner+1) mod NUM_REQ.
  - If no FIFO is non-empty: cdb_out_valid = 0, index and result = 0, rr_ptr unchanged.
- Latency: an entry pushed at edge t is broadcast at edge t+1 at the earliest, and stays visible for exactly one cycle.
- Throughput: one broadcast per cycle.
- Simultaneous push and pop on the same FIFO:
  - Count unchanged; ordering preserved.
  - A full FIFO still shows stall that cycle; there is no pass-through.
- Wrap-around: FIFO read and write pointers wrap modulo FIFO_DEPTH. The rr_ptr wraps from NUM_REQ-1 to 0.
- Flush:
  - At the next edge, all FIFOs are cleared and cdb_out_valid goes to 0 with index and result 0.
  - Pushes in the same cycle are dropped; flush wins.
  - rr_ptr is kept.
- Reset asserted mid-operation clears everything immediately (async), including any in-flight broadcast.
- Fairness: while all requesters are continuously non-empty, each one is granted every NUM_REQ cycles.

Optional Feature:
- Macro: CDB_PERF_CNT_EN.
- When defined, the block adds:
  - Output perf_grant_cnt (NUM_REQ*16): per-requester 16-bit grant counters. They saturate at 0xFFFF and are cleared by rst only, not by flush.
  - Output perf_conflict_cnt (16): counts cycles in which ≥2 FIFOs are non-empty, also saturating.
- When undefined, these ports and registers do not exist and the functionality is identical.

Decomposition:
- Shared package/defines header holds:
  - INDEX_W and DATA_W (the Reg_Lock_Width / Data_Width equivalents).
  - The Reg_No_Lock = 0 constant.
  - Requester ID constants (REQ_ALU = 0, REQ_LSM = 1, REQ_BRA = 2).
- One sub-module, cdb_req_fifo:
  - Parameterised depth and width, with async reset and sync flush.
  - Outputs empty, full and head.
  - Instantiated NUM_REQ times via generate.
- The arbiter logic lives in the top module.

Test Plan:
1. Single push: ALU pushes (index 3, 0x12345678) at edge 1. At edge 2: cdb_out_valid = 1, index 3, result 0x12345678, src 0. At edge 3: valid = 0, index 0.
2. Round-robin: all three push at edge 1 (tags 1, 2, 3) with rr_ptr = 0. Broadcasts at edges 2, 3, 4 carry tags 1, 2, 3. rr_ptr ends at 0.
3. Stall: LSM pushes at 3 consecutive edges while ALU holds priority. After two entries req_stall[1] = 1 and the third push is dropped. Stall clears the cycle after LSM's first pop.
4. Flush: two entries queued in BRA plus a simultaneous ALU push, with flush = 1. At the next edge all FIFOs are empty, no broadcast follows, and req_stall = 0.
5. Index 0 push: a push with index 0 produces no broadcast and leaves the FIFO count at 0.
6. Async reset mid-broadcast: assert rst between edges while cdb_out_valid = 1. Outputs go to 0 immediately, without waiting for a clock edge.
